// File: rtl/hpi_responder.sv
// HPI slave: 256x16 word RAM behind an auto-incrementing byte pointer, plus
// host->local and local->host mailboxes, a sticky error flag and an interrupt.
module hpi_responder (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  otg_hpi_address,
    input  logic        otg_hpi_cs,
    input  logic        otg_hpi_r,
    input  logic        otg_hpi_w,
    input  logic        otg_hpi_reset,
    input  logic [15:0] otg_hpi_data_in,
    output logic [15:0] otg_hpi_data_out,
    output logic        hpi_int,
    output logic [15:0] host_mbx_data,
    output logic        host_mbx_full,
    input  logic        host_mbx_ack,
    input  logic [15:0] dev_mbx_data,
    input  logic        dev_mbx_post
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MBX  = 2'd1;
    localparam logic [1:0] A_ADDR = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    state_t      state_q;
    logic [15:0] ptr_q;
    logic [1:0]  addr_q;
    logic        r_q, w_q;
    logic        wr_inc_q;
    logic        err_q;
    logic [15:0] dout_q;
    logic [15:0] host_data_q, dev_data_q;
    logic        host_full_q, dev_full_q;
    logic [15:0] mem [256];

    logic sel, both_lo, rd_start, wr_start, rd_end, wr_end, mem_we;

    assign sel      = !otg_hpi_cs;
    assign both_lo  = sel && !otg_hpi_r && !otg_hpi_w;
    assign rd_start = (state_q == IDLE) && sel && !otg_hpi_r && r_q && otg_hpi_w;
    assign wr_start = (state_q == IDLE) && sel && !otg_hpi_w && w_q && otg_hpi_r;
    assign rd_end   = (state_q == READ)  && (otg_hpi_r || otg_hpi_cs);
    assign wr_end   = (state_q == WRITE) && (otg_hpi_w || otg_hpi_cs);
    assign mem_we   = wr_start && (otg_hpi_address == A_DATA) && otg_hpi_reset && !reset_reset;

    // RAM is deliberately outside the reset domain so its contents survive resets
    always_ff @(posedge clk_clk) begin
        if (mem_we) mem[ptr_q[8:1]] <= otg_hpi_data_in;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            addr_q      <= A_DATA;
            r_q         <= 1'b1;
            w_q         <= 1'b1;
            wr_inc_q    <= 1'b0;
            err_q       <= 1'b0;
            dout_q      <= '0;
            host_data_q <= '0;
            dev_data_q  <= '0;
            host_full_q <= 1'b0;
            dev_full_q  <= 1'b0;
        end else begin
            r_q <= otg_hpi_r;
            w_q <= otg_hpi_w;
            if (!otg_hpi_reset) begin
                state_q     <= IDLE;
                ptr_q       <= '0;
                wr_inc_q    <= 1'b0;
                err_q       <= 1'b0;
                dout_q      <= '0;
                host_data_q <= '0;
                dev_data_q  <= '0;
                host_full_q <= 1'b0;
                dev_full_q  <= 1'b0;
            end else begin
                wr_inc_q <= 1'b0;
                if (wr_inc_q) ptr_q <= ptr_q + 16'd2;

                // A host write beats a same-cycle ack; a local post beats a same-cycle read clear
                if (wr_start && otg_hpi_address == A_MBX) begin
                    host_data_q <= otg_hpi_data_in;
                    host_full_q <= 1'b1;
                end else if (host_mbx_ack) begin
                    host_full_q <= 1'b0;
                end
                if (dev_mbx_post) begin
                    dev_data_q <= dev_mbx_data;
                    dev_full_q <= 1'b1;
                end else if (rd_end && !both_lo && addr_q == A_MBX) begin
                    dev_full_q <= 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        if (both_lo) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else if (rd_start) begin
                            state_q <= READ;
                            addr_q  <= otg_hpi_address;
                            case (otg_hpi_address)
                                A_DATA:  dout_q <= mem[ptr_q[8:1]];
                                A_MBX:   dout_q <= dev_data_q;
                                A_ADDR:  dout_q <= ptr_q;
                                default: dout_q <= {err_q, 13'b0, dev_full_q, host_full_q};
                            endcase
                        end else if (wr_start) begin
                            state_q <= WRITE;
                            addr_q  <= otg_hpi_address;
                            if (otg_hpi_address == A_ADDR) ptr_q <= otg_hpi_data_in;
                            if (otg_hpi_address == A_DATA) wr_inc_q <= 1'b1;
                        end
                    end
                    READ: begin
                        if (both_lo) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            dout_q  <= '0;
                        end else if (rd_end) begin
                            state_q <= IDLE;
                            dout_q  <= '0;
                            if (addr_q == A_DATA) ptr_q <= ptr_q + 16'd2;
                            if (addr_q == A_STAT) err_q <= 1'b0;
                        end
                    end
                    WRITE: begin
                        if (both_lo) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else if (wr_end) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        if (otg_hpi_r && otg_hpi_w) state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign otg_hpi_data_out = dout_q;
    assign hpi_int          = dev_full_q;
    assign host_mbx_data    = host_data_q;
    assign host_mbx_full    = host_full_q;
endmodule

// File: tb/tb_hpi_responder.sv
// Scoreboard bench for hpi_responder: a behavioural model predicts each read,
// the prediction is queued at drive time and popped when the read data appears.
module tb_hpi_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        cs = 1'b1, r = 1'b1, w = 1'b1, srst_n = 1'b1;
    logic [15:0] din = '0, dout, host_data, dev_data = '0;
    logic        irq, host_full, ack = 1'b0, post = 1'b0;

    hpi_responder dut (
        .clk_clk(clk), .reset_reset(rst), .otg_hpi_address(addr), .otg_hpi_cs(cs),
        .otg_hpi_r(r), .otg_hpi_w(w), .otg_hpi_reset(srst_n), .otg_hpi_data_in(din),
        .otg_hpi_data_out(dout), .hpi_int(irq), .host_mbx_data(host_data),
        .host_mbx_full(host_full), .host_mbx_ack(ack), .dev_mbx_data(dev_data),
        .dev_mbx_post(post)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    logic [15:0] sb[$];
    logic [15:0] mmem [256];
    logic [15:0] mptr = '0, mdevd = '0;
    logic        mdev = 1'b0, mhost = 1'b0, merr = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_rst();
        mptr = '0; mdevd = '0; mdev = 1'b0; mhost = 1'b0; merr = 1'b0;
    endtask

    // blk: access issued while the soft reset holds, so the model is not touched
    task automatic wr(input logic [1:0] a, input logic [15:0] d, input bit ack_too, input bit blk);
        @(negedge clk);
        cs = 1'b0; addr = a; din = d; w = 1'b0; ack = ack_too;
        @(negedge clk);
        ack = 1'b0; w = 1'b1; cs = 1'b1;
        @(negedge clk);
        if (!blk) begin
            case (a)
                2'd0: begin mmem[mptr[8:1]] = d; mptr = mptr + 16'd2; end
                2'd1: mhost = 1'b1;
                2'd2: mptr = d;
                default: ;
            endcase
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input bit pst, input logic [15:0] pd,
                      input bit cs_only);
        logic [15:0] e;
        case (a)
            2'd0: e = mmem[mptr[8:1]];
            2'd1: e = mdevd;
            2'd2: e = mptr;
            default: e = {merr, 13'b0, mdev, mhost};
        endcase
        sb.push_back(e);
        @(negedge clk);
        cs = 1'b0; addr = a; r = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        chk(tag, dout, e);
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_hold"}, dout, e);
        end
        cs = 1'b1;
        if (!cs_only) r = 1'b1;
        if (pst) begin post = 1'b1; dev_data = pd; end
        @(negedge clk);
        post = 1'b0; r = 1'b1;
        chk({tag, "_idle"}, dout, 16'h0000);
        case (a)
            2'd0: mptr = mptr + 16'd2;
            2'd1: mdev = pst;
            3: merr = 1'b0;
            default: ;
        endcase
        if (pst) mdevd = pd;
    endtask

    task automatic dpost(input logic [15:0] d);
        @(negedge clk);
        post = 1'b1; dev_data = d;
        @(negedge clk);
        post = 1'b0;
        mdev = 1'b1; mdevd = d;
    endtask

    initial begin
        foreach (mmem[i]) mmem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_int", {15'b0, irq}, 16'h0);
        chk("rst_hfull", {15'b0, host_full}, 16'h0);
        chk("rst_hdata", host_data, 16'h0000);
        rst = 1'b0;
        rd("rst_ptr", 2'd2, 0, 0, 0);

        // preload word 10 so the streaming read has a known third value
        wr(2'd2, 16'h0014, 0, 0);
        wr(2'd0, 16'hC3C3, 0, 0);

        wr(2'd2, 16'h0010, 0, 0);
        wr(2'd0, 16'hA5A5, 0, 0);
        wr(2'd0, 16'h5A5A, 0, 0);
        rd("ptr_after_wr", 2'd2, 0, 0, 0);
        chk("ptr_model", mptr, 16'h0014);

        wr(2'd2, 16'h0010, 0, 0);
        rd("stream0", 2'd0, 0, 0, 0);
        rd("stream1", 2'd0, 0, 0, 0);
        rd("stream2", 2'd0, 0, 0, 0);
        chk("stream_vals", mmem[8] ^ mmem[9] ^ mmem[10], 16'hA5A5 ^ 16'h5A5A ^ 16'hC3C3);

        wr(2'd2, 16'h01FE, 0, 0);
        wr(2'd0, 16'h1111, 0, 0);
        wr(2'd0, 16'h2222, 0, 0);
        rd("wrap_ptr", 2'd2, 0, 0, 0);
        wr(2'd2, 16'h0000, 0, 0);
        rd("wrap_mem0", 2'd0, 0, 0, 0);
        wr(2'd2, 16'h01FE, 0, 0);
        rd("wrap_mem255", 2'd0, 0, 0, 0);

        dpost(16'h1234);
        chk("post_int", {15'b0, irq}, 16'h1);
        rd("stat_post", 2'd3, 0, 0, 0);
        rd("mbx_rd", 2'd1, 0, 0, 0);
        @(negedge clk);
        chk("int_clr", {15'b0, irq}, 16'h0);
        dpost(16'h5678);
        rd("mbx_race", 2'd1, 1, 16'h9ABC, 0);
        @(negedge clk);
        chk("int_race", {15'b0, irq}, 16'h1);
        rd("stat_race", 2'd3, 0, 0, 0);
        rd("mbx_new", 2'd1, 0, 0, 0);

        wr(2'd1, 16'hBEEF, 0, 0);
        chk("hmbx_data", host_data, 16'hBEEF);
        chk("hmbx_full", {15'b0, host_full}, 16'h1);
        rd("stat_host", 2'd3, 0, 0, 0);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        mhost = 1'b0;
        chk("hmbx_ack", {15'b0, host_full}, 16'h0);
        wr(2'd1, 16'hCAFE, 1, 0);
        chk("hmbx_race", {15'b0, host_full}, 16'h1);
        chk("hmbx_race_d", host_data, 16'hCAFE);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        mhost = 1'b0;

        wr(2'd2, 16'h0010, 0, 0);
        @(negedge clk);
        cs = 1'b0; addr = 2'd0; din = 16'hFFFF; r = 1'b0; w = 1'b0;
        repeat (2) @(negedge clk);
        r = 1'b1; w = 1'b1; cs = 1'b1;
        @(negedge clk);
        merr = 1'b1;
        rd("err_ptr", 2'd2, 0, 0, 0);
        rd("err_stat", 2'd3, 0, 0, 0);
        rd("err_clr", 2'd3, 0, 0, 0);
        rd("err_mem", 2'd0, 0, 0, 1);
        rd("cs_end_ptr", 2'd2, 0, 0, 0);

        wr(2'd2, 16'h0020, 0, 0);
        @(negedge clk);
        cs = 1'b0; addr = 2'd0; din = 16'h7777; w = 1'b0;
        @(negedge clk);
        rst = 1'b1; w = 1'b1; cs = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mmem[16] = 16'h7777;
        model_rst();
        rd("rst_mid_ptr", 2'd2, 0, 0, 0);
        wr(2'd2, 16'h0020, 0, 0);
        rd("rst_mid_mem", 2'd0, 0, 0, 0);

        dpost(16'h4444);
        @(negedge clk); srst_n = 1'b0;
        wr(2'd0, 16'hDEAD, 0, 1);
        srst_n = 1'b1;
        model_rst();
        chk("srst_int", {15'b0, irq}, 16'h0);
        rd("srst_ptr", 2'd2, 0, 0, 0);
        rd("srst_blk", 2'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
